// File: rtl/router_port_serializer.sv
// Transmit side of one router output port.
// Packet bytes arrive on a valid/ready byte interface into a small FIFO and
// leave LSB-first on the 1-bit router channel (dout / valido_n / frameo_n).
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  byte handshake; a push happens when both are high
//   in_data, in_last   payload byte and end-of-packet flag
//   dout               serial data, LSB first (registered)
//   valido_n           active-low: dout carries a valid bit (registered)
//   frameo_n           active-low: packet in progress, high on the last bit (registered)
//   busy               FIFO non-empty or FSM not idle
//   underrun           one-cycle pulse when the frame stalls waiting for data
module router_port_serializer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       dout,
  output logic       valido_n,
  output logic       frameo_n,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // Gap counter is loaded with GAP_CYCLES-1 and counts down to zero.
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StStall, StGap} state_e;

  // FIFO: entries are {last, data}
  logic [8:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, fifo_empty;
  logic [8:0]      head;

  state_e          state_q, state_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            last_q, last_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [GapW-1:0] gapcnt_q, gapcnt_d;
  logic            dout_q, dout_d;
  logic            valido_n_q, valido_n_d;
  logic            frameo_n_q, frameo_n_d;
  logic            underrun_q, underrun_d;

  // No pass-through: a full FIFO refuses even if it pops this cycle.
  assign in_ready   = (count_q < CntW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_last, in_data};
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    last_d   = last_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        pop = !fifo_empty;
      end
      StShift: begin
        if (bitcnt_q == 3'd7) begin
          if (last_q) begin
            if (GAP_CYCLES == 0) begin
              state_d = StIdle;
            end else begin
              state_d  = StGap;
              gapcnt_d = GapLoad;
            end
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d = StStall;
          end
        end else begin
          bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      StStall: begin
        pop = !fifo_empty;
      end
      StGap: begin
        // The final gap cycle hands over straight to the next byte so the
        // idle stretch between packets is exactly GAP_CYCLES long.
        if (gapcnt_q == '0) begin
          state_d = StIdle;
          pop     = !fifo_empty;
        end else begin
          gapcnt_d = gapcnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shreg_d  = head[7:0];
      last_d   = head[8];
      bitcnt_d = 3'd0;
      state_d  = StShift;
    end
  end

  // Outputs are registered from next-state so they line up with the state
  // they describe.
  always_comb begin
    dout_d     = 1'b0;
    valido_n_d = 1'b1;
    frameo_n_d = 1'b1;
    if (state_d == StShift) begin
      dout_d     = shreg_d[bitcnt_d];
      valido_n_d = 1'b0;
      frameo_n_d = last_d && (bitcnt_d == 3'd7);
    end else if (state_d == StStall) begin
      frameo_n_d = 1'b0;
    end
    underrun_d = (state_d == StStall) && (state_q != StStall);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      shreg_q    <= '0;
      last_q     <= 1'b0;
      bitcnt_q   <= '0;
      gapcnt_q   <= '0;
      dout_q     <= 1'b0;
      valido_n_q <= 1'b1;
      frameo_n_q <= 1'b1;
      underrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q    <= count_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      last_q     <= last_d;
      bitcnt_q   <= bitcnt_d;
      gapcnt_q   <= gapcnt_d;
      dout_q     <= dout_d;
      valido_n_q <= valido_n_d;
      frameo_n_q <= frameo_n_d;
      underrun_q <= underrun_d;
    end
  end

  assign dout     = dout_q;
  assign valido_n = valido_n_q;
  assign frameo_n = frameo_n_q;
  assign underrun = underrun_q;
  assign busy     = (count_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_router_port_serializer.sv
// Bench for router_port_serializer. Two instances share the byte inputs:
// dut (GAP_CYCLES=1) is checked by a bit-level scoreboard, dut2
// (GAP_CYCLES=2) is used for the inter-packet gap timing.
module tb_router_port_serializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       in_ready, dout, valido_n, frameo_n, busy, underrun;
  logic       in_ready2, dout2, valido_n2, frameo_n2, busy2, underrun2;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];  // {dout, frameo_n} per expected valid bit
  bit         mon_en = 1'b1;
  bit         ready_low_seen = 1'b0;

  router_port_serializer #(.DEPTH(4), .GAP_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .dout(dout), .valido_n(valido_n),
    .frameo_n(frameo_n), .busy(busy), .underrun(underrun)
  );

  router_port_serializer #(.DEPTH(4), .GAP_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready2), .dout(dout2), .valido_n(valido_n2),
    .frameo_n(frameo_n2), .busy(busy2), .underrun(underrun2)
  );

  always #5 clock = ~clock;

  // Offer one byte, hold in_valid until accepted, then queue its 8 bits.
  task automatic push(input logic [7:0] d, input logic l);
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clock);
      acc = in_ready;
      if (!acc) ready_low_seen = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_accept byte=%h in_ready stayed 0, required 1", d);
    end else begin
      for (int i = 0; i < 8; i++) exp_q.push_back({d[i], l && (i == 7)});
    end
  endtask

  task automatic run_monitor();
    logic [1:0] e;
    forever begin
      @(negedge clock);
      if (mon_en && !reset && valido_n === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL serial_bit got unexpected valid bit dout=%b, required none", dout);
        end else begin
          e = exp_q.pop_front();
          if ({dout, frameo_n} !== e) begin
            errors++;
            $display("FAIL serial_bit got dout=%b frameo_n=%b, required dout=%b frameo_n=%b",
                     dout, frameo_n, e[1], e[0]);
          end
        end
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clock);
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({dout, valido_n, frameo_n, busy, underrun, in_ready} !== 6'b011001) begin
      errors++;
      $display("FAIL reset_outputs got %b, required 011001",
               {dout, valido_n, frameo_n, busy, underrun, in_ready});
    end
    checks++;
    if ({dout2, valido_n2, frameo_n2, busy2, underrun2, in_ready2} !== 6'b011001) begin
      errors++;
      $display("FAIL reset_outputs2 got %b, required 011001",
               {dout2, valido_n2, frameo_n2, busy2, underrun2, in_ready2});
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({busy, valido_n, in_ready} !== 3'b011) begin
      errors++;
      $display("FAIL after_reset got busy,valido_n,in_ready=%b, required 011",
               {busy, valido_n, in_ready});
    end
  endtask

  task automatic test_single();
    logic [7:0] v = 8'hA5;
    bit ok;
    push(v, 1'b1);                 // accepted end of cycle 0, now in cycle 1
    @(negedge clock);
    checks++;
    if (valido_n !== 1'b1) begin
      errors++;
      $display("FAIL single_latency cycle1 valido_n=%b, required 1", valido_n);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++;
      if ({dout, valido_n, frameo_n} !== {v[i], 1'b0, (i == 7)}) begin
        errors++;
        $display("FAIL single_bit%0d got dout,valido_n,frameo_n=%b, required %b", i,
                 {dout, valido_n, frameo_n}, {v[i], 1'b0, (i == 7)});
      end
    end
    @(negedge clock);
    checks++;
    if ({valido_n, frameo_n, busy} !== 3'b111) begin
      errors++;
      $display("FAIL single_gap got valido_n,frameo_n,busy=%b, required 111",
               {valido_n, frameo_n, busy});
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle busy=%b, required 0", busy);
    end
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain idle=%0b left=%0d, required idle=1 left=0", ok, exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    fork
      begin
        push(8'h01, 1'b0);
        push(8'h80, 1'b0);
        push(8'hFF, 1'b1);
      end
      begin
        int w = 0;
        @(negedge clock);
        while (valido_n !== 1'b0 && w < 20) begin
          @(negedge clock);
          w++;
        end
        checks++;
        if (valido_n !== 1'b0) begin
          errors++;
          $display("FAIL b2b_start valido_n=%b after 20 cycles, required 0", valido_n);
        end else begin
          for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (valido_n !== 1'b0 || frameo_n !== (k == 23)) begin
              errors++;
              $display("FAIL b2b_bit%0d got valido_n=%b frameo_n=%b, required 0 %b", k,
                       valido_n, frameo_n, (k == 23));
            end
          end
        end
      end
    join
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain idle=%0b left=%0d, required idle=1 left=0", ok, exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_stall();
    bit ok;
    push(8'h0F, 1'b0);             // now in cycle 1
    repeat (9) @(negedge clock);   // cycles 1..9, bits at 2..9
    @(negedge clock);              // cycle 10
    checks++;
    if ({valido_n, frameo_n, underrun} !== 3'b101) begin
      errors++;
      $display("FAIL stall_entry got valido_n,frameo_n,underrun=%b, required 101",
               {valido_n, frameo_n, underrun});
    end
    @(negedge clock);              // cycle 11
    checks++;
    if ({valido_n, frameo_n, underrun} !== 3'b100) begin
      errors++;
      $display("FAIL stall_hold got valido_n,frameo_n,underrun=%b, required 100",
               {valido_n, frameo_n, underrun});
    end
    @(posedge clock);
    @(posedge clock);
    #1;                            // cycle 13
    push(8'hF0, 1'b1);             // accepted end of 13, now cycle 14
    @(negedge clock);
    checks++;
    if ({valido_n, frameo_n} !== 2'b10) begin
      errors++;
      $display("FAIL stall_wait got valido_n,frameo_n=%b, required 10", {valido_n, frameo_n});
    end
    @(negedge clock);              // cycle 15
    checks++;
    if ({valido_n, dout, underrun} !== 3'b000) begin
      errors++;
      $display("FAIL stall_resume got valido_n,dout,underrun=%b, required 000",
               {valido_n, dout, underrun});
    end
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain idle=%0b left=%0d, required idle=1 left=0", ok, exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_fill();
    bit ok;
    ready_low_seen = 1'b0;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b0);
    push(8'h55, 1'b0);
    push(8'h66, 1'b1);
    checks++;
    if (ready_low_seen !== 1'b1) begin
      errors++;
      $display("FAIL fill_ready in_ready low seen=%0b, required 1", ready_low_seen);
    end
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fill_drain idle=%0b left=%0d, required idle=1 left=0", ok, exp_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_gap();
    bit ok;
    logic [7:0] a = 8'h3C;
    logic [7:0] b = 8'hC3;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    fork
      begin
        push(a, 1'b1);
        push(b, 1'b1);
      end
      begin
        int w = 0;
        int n = 0;
        @(negedge clock);
        while (valido_n2 !== 1'b0 && w < 20) begin
          @(negedge clock);
          w++;
        end
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clock);
          checks++;
          if ({valido_n2, dout2, frameo_n2} !== {1'b0, a[i], (i == 7)}) begin
            errors++;
            $display("FAIL gap_first_bit%0d got %b, required %b", i,
                     {valido_n2, dout2, frameo_n2}, {1'b0, a[i], (i == 7)});
          end
        end
        @(negedge clock);
        while (valido_n2 === 1'b1 && frameo_n2 === 1'b1 && n < 10) begin
          n++;
          @(negedge clock);
        end
        checks++;
        if (n != 2 || valido_n2 !== 1'b0 || underrun2 !== 1'b0) begin
          errors++;
          $display("FAIL gap_length idle=%0d valido_n=%b underrun=%b, required 2 0 0",
                   n, valido_n2, underrun2);
        end
        for (int i = 0; i < 8; i++) begin
          if (i > 0) @(negedge clock);
          checks++;
          if ({valido_n2, dout2, frameo_n2} !== {1'b0, b[i], (i == 7)}) begin
            errors++;
            $display("FAIL gap_second_bit%0d got %b, required %b", i,
                     {valido_n2, dout2, frameo_n2}, {1'b0, b[i], (i == 7)});
          end
        end
      end
    join
    wait_idle(ok);
    repeat (4) @(negedge clock);
    checks++;
    if (!ok || exp_q.size() != 0 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL gap_drain idle=%0b left=%0d busy2=%b, required 1 0 0",
               ok, exp_q.size(), busy2);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_mid_reset();
    bit ok;
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);             // now in cycle 4; bit4 of 0x11 is cycle 6
    repeat (3) @(negedge clock);
    checks++;
    if (valido_n !== 1'b0) begin
      errors++;
      $display("FAIL midreset_streaming valido_n=%b, required 0", valido_n);
    end
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    checks++;
    if ({dout, valido_n, frameo_n} !== 3'b011) begin
      errors++;
      $display("FAIL midreset_async got dout,valido_n,frameo_n=%b, required 011",
               {dout, valido_n, frameo_n});
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({busy, in_ready, valido_n, frameo_n} !== 4'b0111) begin
      errors++;
      $display("FAIL midreset_release got busy,in_ready,valido_n,frameo_n=%b, required 0111",
               {busy, in_ready, valido_n, frameo_n});
    end
    mon_en = 1'b1;
    @(posedge clock);
    #1;
    push(8'h5A, 1'b1);
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_drain idle=%0b left=%0d, required idle=1 left=0",
               ok, exp_q.size());
    end
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fill();
    test_gap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_port_serializer.md
Name: router_port_serializer

Overview:
- Transmit side of one router output port.
- Accepts packet bytes over a valid/ready byte interface into a small internal FIFO.
- Serialises each byte LSB-first onto the router's 1-bit output channel (dout, valido_n, frameo_n), using the same framing that the bench Receiver samples.
- One instance per output port; 16 instances in the 16x16 router.

Parameters:
DEPTH, 4, byte FIFO entries; power of 2, at least 2
GAP_CYCLES, 1, idle cycles forced between packets (frameo_n=1, valido_n=1); 0 allowed

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  byte offered
in_data  input  8  payload byte
in_last  input  1  byte is last of packet
in_ready  output  1  FIFO can accept a byte
dout  output  1  serial data, LSB first
valido_n  output  1  active-low, dout valid
frameo_n  output  1  active-low, packet in progress; high on the last bit
busy  output  1  FIFO non-empty or state != IDLE
underrun  output  1  one-cycle pulse on entry to STALL

Behaviour:
- Interface decisions: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values (async, while reset=1): dout=0, valido_n=1, frameo_n=1, busy=0, underrun=0. FIFO is flushed, state=IDLE, bit counter=0, gap counter=0.
- Reset mid-packet abandons the packet immediately. No partial frame completion.
- in_ready = (count < DEPTH), combinational, so it reads 1 during and after reset.
- Push occurs when in_valid && in_ready. When full, in_ready=0 even if a pop happens in the same cycle (no pass-through).
- Simultaneous push and pop when not full: count is unchanged.
- FIFO entries are {last, data[7:0]}. Pointers wrap modulo DEPTH. count width is $clog2(DEPTH+1).
- dout, valido_n and frameo_n are registered.
- State machine:
  - IDLE:
    - Outputs dout=0, valido_n=1, frameo_n=1.
    - If FIFO non-empty: pop into shift register, bit counter=0, go to SHIFT.
    - Latency: a byte pushed into an empty FIFO in cycle N is popped in N+1, and bit0 appears on dout in N+2.
  - SHIFT:
    - Each cycle drives dout=shreg[bitcnt], valido_n=0, frameo_n=0.
    - Exception: frameo_n=1 while driving bit7 of a byte flagged last.
    - At bitcnt==7, not last, FIFO non-empty: pop in the same cycle; the next cycle drives bit0 of the new byte with no bubble.
    - At bitcnt==7, not last, FIFO empty: go to STALL.
    - At bitcnt==7, last: go to GAP, or to IDLE when GAP_CYCLES=0.
  - STALL:
    - Outputs dout=0, valido_n=1, frameo_n=0 (frame held open).
    - underrun pulses for 1 cycle on entry.
    - When FIFO non-empty: pop, return to SHIFT; bit0 appears the cycle after the pop.
  - GAP:
    - Outputs dout=0, valido_n=1, frameo_n=1.
    - Stays GAP_CYCLES cycles, then IDLE.
    - Pushes are still accepted during GAP.
- A single-byte packet gives frameo_n low for bits 0-6 and high on bit7.
- busy = (count != 0) || (state != IDLE).

Test Plan:
- Reset, then push 0xA5 with last=1 in cycle 0. Required:
  - cycles 2-9: dout = 1,0,1,0,0,1,0,1; valido_n=0.
  - frameo_n=0 for cycles 2-8 and 1 in cycle 9.
  - cycle 10: GAP with valido_n=1; cycle 11: IDLE, busy=0.
- Push 3-byte packet 0x01,0x80,0xFF (last on 0xFF) back-to-back. Required:
  - 24 contiguous valid bits: 1,0000000, 0000000,1, 11111111.
  - frameo_n high only on bit 24.
  - No bubble between bytes.
- Push 0x0F (last=0), wait 12 cycles, push 0xF0 (last=1). Required:
  - After bit7 of 0x0F: STALL with valido_n=1, frameo_n=0, underrun high for exactly 1 cycle.
  - 0xF0 bits start 2 cycles after its push.
- DEPTH=4, push 6 bytes with in_valid held high. Required:
  - in_ready drops to 0 once count reaches 4.
  - All 6 bytes are serialised in order; none is lost or duplicated.
- Two 1-byte packets (0x3C, 0xC3) pushed back-to-back, GAP_CYCLES=2. Required:
  - Exactly 2 cycles with frameo_n=1 and valido_n=1 after the last bit of 0x3C.
  - First bit of 0xC3 follows in the next cycle.
- Assert reset during bit4 of a 4-byte packet. Required:
  - Outputs go idle (dout=0, valido_n=1, frameo_n=1) in the same cycle, before the next clock edge.
  - After release: busy=0, in_ready=1; the next pushed packet serialises correctly from bit0.
